ef_dac_seq_ctrl: RTL and testbench



---
 rtl/ef_dac_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_ef_dac_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_dac_seq_ctrl.sv
// Resistor-string DAC sequencer: sample FIFO, sample-rate prescaler and
// RST strobe generator that latches dac_sel on the strobe's falling edge.
module ef_dac_seq_ctrl #(
    parameter int DW         = 10,
    parameter int FIFO_AW    = 4,
    parameter int CLKDIV_W   = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CLKDIV_W-1:0] clkdiv,
    input  logic                repeat_last,
    input  logic                flush,
    input  logic [DW-1:0]       in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DW-1:0]       dac_sel,
    output logic                dac_rst,
    output logic                dac_en,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                underflow,
    output logic                update_done
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int PCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [PCW-1:0]   PCNT_INIT = PCW'(RST_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PULSE
    } state_t;

    state_t               state_q, state_d;
    logic [CLKDIV_W-1:0]  cnt_q, cnt_d;
    logic [PCW-1:0]       pcnt_q, pcnt_d;
    logic [DW-1:0]        dac_sel_q, dac_sel_d;
    logic                 dac_rst_q, dac_rst_d;
    logic                 dac_en_q;
    logic                 underflow_q, underflow_d;
    logic                 update_done_q, update_done_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [DW-1:0]        mem_q [DEPTH];

    logic tick;
    logic push;
    logic pop;
    logic uf_set;
    logic fifo_avail;

    assign in_ready = (level_q != FULL_LVL);

    always_comb begin
        tick       = en && (cnt_q == clkdiv);
        cnt_d      = (!en || tick) ? '0 : cnt_q + 1'b1;
        // flush makes the FIFO look empty for this cycle, so no pop can race it
        fifo_avail = (level_q != '0) && !flush;
        push       = in_valid && in_ready && !flush;

        pop           = 1'b0;
        uf_set        = 1'b0;
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        dac_sel_d     = dac_sel_q;
        dac_rst_d     = dac_rst_q;
        update_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (fifo_avail) begin
                        pop       = 1'b1;
                        dac_sel_d = mem_q[rd_ptr_q];
                        dac_rst_d = 1'b1;
                        pcnt_d    = PCNT_INIT;
                        state_d   = PULSE;
                    end else if (repeat_last) begin
                        dac_rst_d = 1'b1;
                        pcnt_d    = PCNT_INIT;
                        state_d   = PULSE;
                    end else if (!flush) begin
                        uf_set = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (pcnt_q == '0) begin
                    dac_rst_d     = 1'b0;
                    update_done_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    pcnt_d = pcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        underflow_d = flush ? 1'b0 : (underflow_q | uf_set);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pcnt_q        <= '0;
            dac_sel_q     <= '0;
            dac_rst_q     <= 1'b0;
            dac_en_q      <= 1'b0;
            underflow_q   <= 1'b0;
            update_done_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pcnt_q        <= pcnt_d;
            dac_sel_q     <= dac_sel_d;
            dac_rst_q     <= dac_rst_d;
            dac_en_q      <= en;
            underflow_q   <= underflow_d;
            update_done_q <= update_done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign dac_sel     = dac_sel_q;
    assign dac_rst     = dac_rst_q;
    assign dac_en      = dac_en_q;
    assign fifo_level  = level_q;
    assign underflow   = underflow_q;
    assign update_done = update_done_q;

endmodule

// File: tb/tb_ef_dac_seq_ctrl.sv
// Bench for ef_dac_seq_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_ef_dac_seq_ctrl;

    localparam int DW    = 10;
    localparam int AW    = 4;
    localparam int CW    = 16;
    localparam int RC    = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [CW-1:0] clkdiv;
    logic          repeat_last;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dac_sel;
    logic          dac_rst;
    logic          dac_en;
    logic [AW:0]   fifo_level;
    logic          underflow;
    logic          update_done;

    int checks   = 0;
    int failures = 0;

    ef_dac_seq_ctrl #(
        .DW        (DW),
        .FIFO_AW   (AW),
        .CLKDIV_W  (CW),
        .RST_CYCLES(RC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clkdiv     (clkdiv),
        .repeat_last(repeat_last),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dac_sel    (dac_sel),
        .dac_rst    (dac_rst),
        .dac_en     (dac_en),
        .fifo_level (fifo_level),
        .underflow  (underflow),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    // Behavioural model: sample queue, tick counter and a "strobe cycles left" count.
    int          m_q[$];
    int          m_cnt;
    int          m_hold;
    int          m_sel;
    bit          m_rst, m_en, m_uf, m_done;

    always @(posedge clk or negedge rst_n) begin
        bit tick, idle, has_data, can_push;
        if (!rst_n) begin
            m_q.delete();
            m_cnt = 0; m_hold = 0; m_sel = 0;
            m_rst = 0; m_en = 0; m_uf = 0; m_done = 0;
        end else begin
            tick     = en && (m_cnt == int'(clkdiv));
            idle     = (m_hold == 0);
            has_data = (m_q.size() > 0) && !flush;
            can_push = (m_q.size() != DEPTH);
            m_done   = 0;
            if (!idle) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin
                    m_rst  = 0;
                    m_done = 1;
                end
            end else if (tick) begin
                if (has_data || repeat_last) begin
                    if (has_data) m_sel = m_q.pop_front();
                    m_rst  = 1;
                    m_hold = RC;
                end else if (!flush) begin
                    m_uf = 1;
                end
            end
            if (flush) begin
                m_q.delete();
                m_uf = 0;
            end else if (in_valid && can_push) begin
                m_q.push_back(int'(in_data));
            end
            m_cnt = (!en || tick) ? 0 : ((m_cnt + 1) % 65536);
            m_en  = en;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_val("dac_sel", int'(dac_sel), m_sel);
        check_val("dac_rst", int'(dac_rst), int'(m_rst));
        check_val("dac_en", int'(dac_en), int'(m_en));
        check_val("fifo_level", int'(fifo_level), m_q.size());
        check_val("in_ready", int'(in_ready), int'(m_q.size() != DEPTH));
        check_val("underflow", int'(underflow), int'(m_uf));
        check_val("update_done", int'(update_done), int'(m_done));
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((dac_rst || update_done) && guard < 20) begin
            cyc();
            guard++;
        end
        check_val("idle_timeout", int'(guard < 20), 1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; en = 1'b0; clkdiv = '0; repeat_last = 1'b0;
        flush = 1'b0; in_data = '0; in_valid = 1'b0;
        #1;
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_dac_sel", int'(dac_sel), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Three codes at clkdiv=9: first strobe 10 cycles after en is sampled high.
        clkdiv = 16'd9;
        push_word(10'h3FF);
        push_word(10'h200);
        push_word(10'h001);
        en  = 1'b1;
        lat = 0;
        while (!dac_rst && lat < 50) begin
            cyc();
            lat++;
        end
        check_val("first_tick_latency", lat, 10);
        check_val("first_code", int'(dac_sel), 'h3FF);
        cyc(35);
        en = 1'b0;
        wait_idle();

        // Overfill while disabled, then drain in order.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        check_val("full_level", int'(fifo_level), 16);
        check_val("full_ready", int'(in_ready), 0);
        clkdiv = 16'd3;
        en = 1'b1;
        cyc(16 * 4 + 8);
        check_val("drained_level", int'(fifo_level), 0);
        en = 1'b0;
        wait_idle();

        // Underflow on empty FIFO without repeat.
        clkdiv = 16'd4; repeat_last = 1'b0;
        en = 1'b1;
        cyc(12);
        check_val("underflow_set", int'(underflow), 1);
        check_val("underflow_no_strobe", int'(dac_rst), 0);
        en = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        check_val("underflow_cleared", int'(underflow), 0);

        // Repeat-last re-latches 0x155.
        push_word(10'h155);
        repeat_last = 1'b1;
        en = 1'b1;
        cyc(30);
        check_val("repeat_sel", int'(dac_sel), 'h155);
        check_val("repeat_no_uf", int'(underflow), 0);
        en = 1'b0; repeat_last = 1'b0;
        wait_idle();

        // clkdiv=0: one update every RC+1 cycles.
        clkdiv = '0;
        for (int i = 0; i < 4; i++) push_word(DW'($urandom));
        en = 1'b1;
        cyc(16);
        check_val("fast_drained", int'(fifo_level), 0);
        en = 1'b0;
        wait_idle();

        // Random traffic; clkdiv only changes while disabled.
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 2) != 0);
            in_data     = DW'($urandom);
            flush       = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) repeat_last = ~repeat_last;
            if ($urandom_range(0, 19) == 0) begin
                en = ~en;
                if (!en) clkdiv = CW'($urandom_range(0, 6));
            end
            cyc();
        end
        en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        wait_idle();

        // Asynchronous reset during the strobe.
        clkdiv = 16'd2;
        push_word(10'h2AA);
        en  = 1'b1;
        lat = 0;
        while (!dac_rst && lat < 20) begin
            cyc();
            lat++;
        end
        check_val("pre_reset_strobe", int'(dac_rst), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_dac_rst", int'(dac_rst), 0);
        check_val("async_dac_sel", int'(dac_sel), 0);
        check_val("async_dac_en", int'(dac_en), 0);
        check_val("async_level", int'(fifo_level), 0);
        en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(8);
        check_val("post_reset_quiet", int'(dac_rst), 0);
        en = 1'b1;
        repeat_last = 1'b1;
        cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
